toy_bpu_l0btb_ctrl: RTL and testbench
=====================================

TOY_BPU_L0BTB_CTRL -- requirements
Module: toy_bpu_l0btb_ctrl

Interface
REQ-001 Parameter ENTRY_NUM, default 8, number of managed L0 BTB entries (power of 2, 2..32).
REQ-002 clk  input  1  core clock; all state on posedge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 flush_req  input  1  level request to invalidate every entry.
REQ-005 flush_busy  output  1  high while the flush walk is in progress.
REQ-006 train_vld / train_rdy  input / output  1 / 1  backend train-update handshake.
REQ-007 train_pld  input  l0btb_entry_pkg  entry payload to write; contains field tag.
REQ-008 kill_vld / kill_rdy  input / output  1 / 1  single-entry invalidate-by-tag handshake.
REQ-009 kill_tag  input  L0BTB_TAG_WIDTH  tag to invalidate.
REQ-010 entry_vld  input  ENTRY_NUM  per-entry valid, driven by the entry array.
REQ-011 entry_pld  input  ENTRY_NUM x l0btb_entry_pkg  per-entry payload from the entry array.
REQ-012 entry_update  output  ENTRY_NUM  one-hot write strobe to the entry array.
REQ-013 entry_update_inv  output  ENTRY_NUM  per-entry invalidate qualifier for the strobe.
REQ-014 entry_update_pld  output  l0btb_entry_pkg  payload broadcast to all entries.

Function
REQ-015 A transfer SHALL occur when vld&&rdy in the same cycle; the strobe SHALL be combinational in that cycle, so the entry state changes at the next posedge (latency 1).
REQ-016 Priority SHALL be flush > kill > train; at most one entry_update bit SHALL be high per cycle, except during the kill match (REQ-019).
REQ-017 FSM states: IDLE, FLUSH. IDLE->FLUSH when flush_req=1; FLUSH->IDLE in the cycle flush_cnt==ENTRY_NUM-1.
REQ-018 In FLUSH, flush_cnt SHALL start at 0 and increment each cycle; entry_update[flush_cnt]=1 and entry_update_inv[flush_cnt]=1; flush_busy=1; train_rdy=kill_rdy=0.
REQ-019 In IDLE, kill_rdy=1; on kill transfer, every entry with entry_vld=1 and tag==kill_tag SHALL get entry_update=1 and entry_update_inv=1; zero matches SHALL be a legal no-op.
REQ-020 In IDLE with no kill transfer, train_rdy SHALL be 1.
REQ-021 Train hit: if a valid entry's tag equals train_pld.tag, that entry (lowest index if several) SHALL be rewritten; the replacement pointer SHALL be unchanged.
REQ-022 Train miss: the victim SHALL be selected per REQ-028; after the write, rr_ptr SHALL become victim+1 modulo ENTRY_NUM (wrapping from ENTRY_NUM-1 to 0).
REQ-023 entry_update_inv SHALL be 0 on train writes; entry_update_pld SHALL equal train_pld whenever a train transfer occurs, else all zero.
REQ-024 flush_req rising in the same cycle as a train or kill transfer: flush wins; the other handshake SHALL see rdy=0 in that cycle.
REQ-025 flush_req held high at the end of a walk SHALL start a new walk at entry 0 immediately.

Reset
REQ-026 On rst_n=0: state=IDLE, flush_cnt=0, rr_ptr=0, flush_busy=0, entry_update=0, entry_update_inv=0, entry_update_pld=0; reset mid-flush SHALL abort the walk without completing it.

Configuration
REQ-027 Macro TOY_BPU_L0BTB_INV_FIRST_EN SHALL select the victim-selection policy for train misses.
REQ-028 Defined: the victim SHALL be the lowest-index entry with entry_vld=0 if any exists, else rr_ptr. Undefined: the victim SHALL always be rr_ptr.

Structure
REQ-029 l0btb_entry_pkg, L0BTB_TAG_WIDTH and the FSM state enum SHALL reside in toy_pack.
REQ-030 Victim selection and rr_ptr SHALL be in sub-module toy_bpu_l0btb_repl (inputs: entry_vld, alloc strobe; output: one-hot victim).

Verification
REQ-031 Reset, then 8 train misses with tags 0x1..0x8 -> entries 0..7 are written in order and rr_ptr returns to 0.
REQ-032 Train with tag 0x3 while entry 2 holds valid tag 0x3 -> entry_update=8'b0000_0100; rr_ptr is unchanged.
REQ-033 kill_tag=0x5 with entries 4 and 6 both holding valid tag 0x5 -> entry_update=entry_update_inv=8'b0101_0000 in one cycle.
REQ-034 flush_req pulse in the same cycle as train_vld -> train_rdy=0; flush_busy=1 for exactly 8 cycles; entries 0..7 are invalidated in order; train is accepted in the cycle after flush_busy falls.
REQ-035 With the macro defined, entry 3 invalid and rr_ptr=6 -> a miss writes entry 3; with the macro undefined, the same stimulus writes entry 6.
REQ-036 rst_n asserted at flush_cnt=4 -> all outputs are 0 immediately; after release state=IDLE and train_rdy=1.

Source files
------------

// File: rtl/toy_bpu_l0btb_ctrl_pkg.sv
// Shared types for the L0 BTB controller: entry payload, tag width and FSM states.
package toy_pack;

  localparam int L0BTB_TAG_WIDTH    = 8;
  localparam int L0BTB_TARGET_WIDTH = 16;

  typedef struct packed {
    logic [L0BTB_TAG_WIDTH-1:0]    tag;
    logic [L0BTB_TARGET_WIDTH-1:0] target;
  } l0btb_entry_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } l0btb_ctrl_state_e;

endpackage

// File: rtl/toy_bpu_l0btb_ctrl_if.sv
// Flush / train / kill handshake bundle between the backend and the L0 BTB controller.
interface toy_bpu_l0btb_ctrl_if;
  import toy_pack::*;

  logic                       flush_req;
  logic                       flush_busy;
  logic                       train_vld;
  logic                       train_rdy;
  l0btb_entry_pkg             train_pld;
  logic                       kill_vld;
  logic                       kill_rdy;
  logic [L0BTB_TAG_WIDTH-1:0] kill_tag;

  modport master (
    output flush_req, train_vld, train_pld, kill_vld, kill_tag,
    input  flush_busy, train_rdy, kill_rdy
  );

  modport slave (
    input  flush_req, train_vld, train_pld, kill_vld, kill_tag,
    output flush_busy, train_rdy, kill_rdy
  );

endinterface

// File: rtl/toy_bpu_l0btb_ctrl_repl.sv
// Victim selection and round-robin pointer for train misses.
// TOY_BPU_L0BTB_INV_FIRST_EN prefers the lowest invalid entry over the round-robin pointer.
module toy_bpu_l0btb_repl #(
  parameter int ENTRY_NUM = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ENTRY_NUM-1:0] i_entry_vld,
  input  logic                 i_alloc,
  output logic [ENTRY_NUM-1:0] o_victim
);

  localparam int PTR_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;

  logic [PTR_W-1:0] r_rr_ptr;
  logic [PTR_W-1:0] w_victim_idx;

`ifdef TOY_BPU_L0BTB_INV_FIRST_EN
  // Descending scan so the lowest invalid index is the one that sticks.
  always_comb begin
    w_victim_idx = r_rr_ptr;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (!i_entry_vld[i]) begin
        w_victim_idx = PTR_W'(i);
      end
    end
  end
`else
  logic w_unused_vld;
  assign w_unused_vld = ^i_entry_vld;

  always_comb begin
    w_victim_idx = r_rr_ptr;
  end
`endif

  assign o_victim = ENTRY_NUM'(1) << w_victim_idx;

  // Power-of-two entry count makes the increment wrap to 0 on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (i_alloc) begin
      r_rr_ptr <= w_victim_idx + 1'b1;
    end
  end

endmodule

// File: rtl/toy_bpu_l0btb_ctrl.sv
// L0 BTB controller: arbitrates flush > kill > train and drives the entry-array write strobes.
// Victim policy selected by TOY_BPU_L0BTB_INV_FIRST_EN (see toy_bpu_l0btb_repl).
module toy_bpu_l0btb_ctrl
  import toy_pack::*;
#(
  parameter int ENTRY_NUM = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  toy_bpu_l0btb_ctrl_if.slave           bus,
  input  logic           [ENTRY_NUM-1:0] i_entry_vld,
  input  l0btb_entry_pkg [ENTRY_NUM-1:0] i_entry_pld,
  output logic           [ENTRY_NUM-1:0] o_entry_update,
  output logic           [ENTRY_NUM-1:0] o_entry_update_inv,
  output l0btb_entry_pkg                 o_entry_update_pld
);

  localparam int                CNT_W    = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ENTRY_NUM - 1);

  l0btb_ctrl_state_e r_state;
  l0btb_ctrl_state_e w_next_state;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic [ENTRY_NUM-1:0] w_hit_vec;
  logic [ENTRY_NUM-1:0] w_hit_onehot;
  logic                 w_hit;
  logic [ENTRY_NUM-1:0] w_kill_match;
  logic [ENTRY_NUM-1:0] w_victim;
  logic                 w_alloc;

  logic                 w_train_rdy;
  logic                 w_kill_rdy;
  logic                 w_flush_busy;
  logic [ENTRY_NUM-1:0] w_update;
  logic [ENTRY_NUM-1:0] w_update_inv;
  l0btb_entry_pkg       w_update_pld;

  logic w_unused_pld;
  assign w_unused_pld = ^i_entry_pld;

  always_comb begin
    w_hit_vec    = '0;
    w_kill_match = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      w_hit_vec[i]    = i_entry_vld[i] && (i_entry_pld[i].tag == bus.train_pld.tag);
      w_kill_match[i] = i_entry_vld[i] && (i_entry_pld[i].tag == bus.kill_tag);
    end
  end

  // Isolate the lowest set bit so a multi-hit rewrites only one entry.
  assign w_hit_onehot = w_hit_vec & (~w_hit_vec + 1'b1);
  assign w_hit        = |w_hit_vec;

  toy_bpu_l0btb_repl #(
    .ENTRY_NUM (ENTRY_NUM)
  ) u_repl (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_entry_vld (i_entry_vld),
    .i_alloc     (w_alloc),
    .o_victim    (w_victim)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_next_state;
      if (r_state == FLUSH && r_flush_cnt != CNT_LAST) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end else begin
        r_flush_cnt <= '0;
      end
    end
  end

  // A flush request in IDLE blocks both handshakes for that cycle before the walk starts.
  always_comb begin
    w_next_state = r_state;
    w_train_rdy  = 1'b0;
    w_kill_rdy   = 1'b0;
    w_flush_busy = 1'b0;
    w_update     = '0;
    w_update_inv = '0;
    w_update_pld = '0;
    w_alloc      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.flush_req) begin
          w_next_state = FLUSH;
        end else begin
          w_kill_rdy = 1'b1;
          if (bus.kill_vld) begin
            w_update     = w_kill_match;
            w_update_inv = w_kill_match;
          end else begin
            w_train_rdy = 1'b1;
            if (bus.train_vld) begin
              w_update_pld = bus.train_pld;
              w_update     = w_hit ? w_hit_onehot : w_victim;
              w_alloc      = !w_hit;
            end
          end
        end
      end
      FLUSH: begin
        w_flush_busy = 1'b1;
        w_update     = ENTRY_NUM'(1) << r_flush_cnt;
        w_update_inv = ENTRY_NUM'(1) << r_flush_cnt;
        if (r_flush_cnt == CNT_LAST) begin
          w_next_state = bus.flush_req ? FLUSH : IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held so nothing is accepted or written.
  assign bus.train_rdy          = rst_n && w_train_rdy;
  assign bus.kill_rdy           = rst_n && w_kill_rdy;
  assign bus.flush_busy         = rst_n && w_flush_busy;
  assign o_entry_update         = rst_n ? w_update     : '0;
  assign o_entry_update_inv     = rst_n ? w_update_inv : '0;
  assign o_entry_update_pld     = rst_n ? w_update_pld : '0;

endmodule

// File: tb/tb_toy_bpu_l0btb_ctrl.sv
// Self-checking bench for toy_bpu_l0btb_ctrl: directed scenarios plus random traffic vs a reference model.
// Honours TOY_BPU_L0BTB_INV_FIRST_EN for the expected victim policy.
module tb_toy_bpu_l0btb_ctrl;
  import toy_pack::*;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  toy_bpu_l0btb_ctrl_if bus();

  logic           [N-1:0] entryVld;
  l0btb_entry_pkg [N-1:0] entryPld;
  logic           [N-1:0] entryUpd;
  logic           [N-1:0] entryUpdInv;
  l0btb_entry_pkg         entryUpdPld;

  toy_bpu_l0btb_ctrl #(.ENTRY_NUM(N)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .bus                (bus.slave),
    .i_entry_vld        (entryVld),
    .i_entry_pld        (entryPld),
    .o_entry_update     (entryUpd),
    .o_entry_update_inv (entryUpdInv),
    .o_entry_update_pld (entryUpdPld)
  );

  int checks = 0;
  int failures = 0;

  bit mFlushing;
  int mCnt;
  int mRr;
  bit nFlushing;
  int nCnt;
  int nRr;

  logic           expTrainRdy, expKillRdy, expBusy;
  logic   [N-1:0] expUpd, expInv;
  l0btb_entry_pkg expPld;

  logic           lastTrainRdy, lastBusy;
  logic   [N-1:0] lastUpd, lastInv;
  l0btb_entry_pkg lastPld;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected outputs and next model state, derived from the arbitration rules.
  task automatic computeModel();
    int hitIdx;
    int v;
    expTrainRdy = 1'b0;
    expKillRdy  = 1'b0;
    expBusy     = 1'b0;
    expUpd      = '0;
    expInv      = '0;
    expPld      = '0;
    nFlushing   = mFlushing;
    nCnt        = mCnt;
    nRr         = mRr;
    if (mFlushing) begin
      expBusy      = 1'b1;
      expUpd[mCnt] = 1'b1;
      expInv[mCnt] = 1'b1;
      if (mCnt == N - 1) begin
        nCnt      = 0;
        nFlushing = bus.flush_req;
      end else begin
        nCnt = mCnt + 1;
      end
    end else if (bus.flush_req) begin
      nFlushing = 1'b1;
      nCnt      = 0;
    end else begin
      expKillRdy = 1'b1;
      if (bus.kill_vld) begin
        for (int i = 0; i < N; i++) begin
          if (entryVld[i] && entryPld[i].tag == bus.kill_tag) begin
            expUpd[i] = 1'b1;
            expInv[i] = 1'b1;
          end
        end
      end else begin
        expTrainRdy = 1'b1;
        if (bus.train_vld) begin
          expPld = bus.train_pld;
          hitIdx = -1;
          for (int i = 0; i < N; i++) begin
            if (hitIdx < 0 && entryVld[i] && entryPld[i].tag == bus.train_pld.tag) hitIdx = i;
          end
          if (hitIdx >= 0) begin
            expUpd[hitIdx] = 1'b1;
          end else begin
            v = mRr;
`ifdef TOY_BPU_L0BTB_INV_FIRST_EN
            for (int i = N - 1; i >= 0; i--) begin
              if (!entryVld[i]) v = i;
            end
`endif
            expUpd[v] = 1'b1;
            nRr = (v + 1) % N;
          end
        end
      end
    end
  endtask

  // Called at a negedge: drive inputs, check, then advance the entry array and model.
  task automatic applyStimulus(input bit fl, input bit tv, input logic [7:0] tTag,
                               input logic [15:0] tTgt, input bit kv, input logic [7:0] kTag,
                               input string name);
    bus.flush_req        = fl;
    bus.train_vld        = tv;
    bus.train_pld.tag    = tTag;
    bus.train_pld.target = tTgt;
    bus.kill_vld         = kv;
    bus.kill_tag         = kTag;
    #1;
    computeModel();
    checkOutput({name, ".train_rdy"}, 64'(bus.train_rdy), 64'(expTrainRdy));
    checkOutput({name, ".kill_rdy"},  64'(bus.kill_rdy),  64'(expKillRdy));
    checkOutput({name, ".busy"},      64'(bus.flush_busy), 64'(expBusy));
    checkOutput({name, ".upd"},       64'(entryUpd),      64'(expUpd));
    checkOutput({name, ".inv"},       64'(entryUpdInv),   64'(expInv));
    checkOutput({name, ".pld"},       64'(entryUpdPld),   64'(expPld));
    lastTrainRdy = bus.train_rdy;
    lastBusy     = bus.flush_busy;
    lastUpd      = entryUpd;
    lastInv      = entryUpdInv;
    lastPld      = entryUpdPld;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (lastUpd[i]) begin
        if (lastInv[i]) begin
          entryVld[i] = 1'b0;
        end else begin
          entryVld[i] = 1'b1;
          entryPld[i] = lastPld;
        end
      end
    end
    mFlushing = nFlushing;
    mCnt      = nCnt;
    mRr       = nRr;
    @(negedge clk);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, ".train_rdy"}, 64'(bus.train_rdy),  64'(0));
    checkOutput({name, ".kill_rdy"},  64'(bus.kill_rdy),   64'(0));
    checkOutput({name, ".busy"},      64'(bus.flush_busy), 64'(0));
    checkOutput({name, ".upd"},       64'(entryUpd),       64'(0));
    checkOutput({name, ".inv"},       64'(entryUpdInv),    64'(0));
    checkOutput({name, ".pld"},       64'(entryUpdPld),    64'(0));
  endtask

  initial begin
    int busyCnt;
    logic [N-1:0] expVictim;
    bus.flush_req = 1'b0;
    bus.train_vld = 1'b0;
    bus.train_pld = '0;
    bus.kill_vld  = 1'b0;
    bus.kill_tag  = '0;
    entryVld      = '0;
    entryPld      = '0;
    mFlushing     = 1'b0;
    mCnt          = 0;
    mRr           = 0;

    @(negedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] fill: 8 misses with tags 1..8");
    for (int i = 0; i < N; i++) begin
      applyStimulus(0, 1, 8'(i + 1), 16'(i * 16'h111), 0, 8'h00, "fill");
      checkOutput("fill.order", 64'(lastUpd), 64'(8'(1) << i));
    end
    applyStimulus(0, 1, 8'h09, 16'hAAAA, 0, 8'h00, "rr_wrap");
    checkOutput("rr_wrap.entry0", 64'(lastUpd), 64'h01);

    $display("[TB] train hit on tag 3");
    applyStimulus(0, 1, 8'h03, 16'h3333, 0, 8'h00, "hit");
    checkOutput("hit.entry2", 64'(lastUpd), 64'h04);
    applyStimulus(0, 1, 8'h0A, 16'hBBBB, 0, 8'h00, "hit_rr");
    checkOutput("hit_rr.entry1", 64'(lastUpd), 64'h02);

    $display("[TB] kill tag 5 matching entries 4 and 6");
    entryPld[6].tag = 8'h05;
    applyStimulus(0, 1, 8'h0C, 16'h0000, 1, 8'h05, "kill");
    checkOutput("kill.upd",  64'(lastUpd), 64'h50);
    checkOutput("kill.inv",  64'(lastInv), 64'h50);
    applyStimulus(0, 0, 8'h00, 16'h0000, 1, 8'hEE, "kill_none");
    checkOutput("kill_none.upd", 64'(lastUpd), 64'h00);

    $display("[TB] flush pulse colliding with train");
    applyStimulus(1, 1, 8'h11, 16'h1111, 0, 8'h00, "flush_start");
    checkOutput("flush_start.train_rdy", 64'(lastTrainRdy), 64'(0));
    busyCnt = 0;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(0, 1, 8'h11, 16'h1111, 0, 8'h00, "flush_walk");
      if (!lastBusy) break;
      checkOutput("flush_walk.order", 64'(lastInv), 64'(8'(1) << busyCnt));
      busyCnt++;
    end
    checkOutput("flush.busy_cycles", 64'(busyCnt), 64'(8));
    checkOutput("flush.train_accept", 64'(lastTrainRdy && (|lastUpd)), 64'(1));

    $display("[TB] reset in the middle of a flush walk");
    applyStimulus(1, 0, 8'h00, 16'h0000, 0, 8'h00, "abort_start");
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 8'h00, 16'h0000, 0, 8'h00, "abort_walk");
    checkOutput("abort.busy_before", 64'(bus.flush_busy), 64'(1));
    rst_n = 1'b0;
    #1;
    checkAllZero("abort_reset");
    mFlushing = 1'b0;
    mCnt      = 0;
    mRr       = 0;
    entryVld  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 8'h00, 16'h0000, 0, 8'h00, "after_reset");
    checkOutput("after_reset.train_rdy", 64'(lastTrainRdy), 64'(1));

    $display("[TB] victim policy with entry 3 invalid and rr pointer at 6");
    for (int i = 0; i < N; i++) applyStimulus(0, 1, 8'(8'h21 + i), 16'(i), 0, 8'h00, "refill");
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 8'(8'h31 + i), 16'(i), 0, 8'h00, "advance");
    entryVld[3] = 1'b0;
`ifdef TOY_BPU_L0BTB_INV_FIRST_EN
    expVictim = 8'h08;
`else
    expVictim = 8'h40;
`endif
    applyStimulus(0, 1, 8'h40, 16'h4040, 0, 8'h00, "policy");
    checkOutput("policy.victim", 64'(lastUpd), 64'(expVictim));

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(0, 24) == 0, $urandom_range(0, 9) < 6,
                    8'($urandom_range(0, 15)), 16'($urandom), $urandom_range(0, 4) == 0,
                    8'($urandom_range(0, 15)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
